// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants and state encoding for the fetch stage
package fetch_stage_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    HOLD    = 2'b01,
    DISCARD = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// rtl/fetch_stage_pc_register.sv - loadable request-address register with synchronous reset
import fetch_stage_pkg::*;

module pc_register #(
  parameter logic [INSTR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [INSTR_W-1:0] d,
  output logic [INSTR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= RESET_PC;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with stall buffering and redirect flush
import fetch_stage_pkg::*;

module fetch_stage #(
  parameter logic [INSTR_W-1:0] RESET_PC  = 32'h00000000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirectTarget,
  output logic               imemReq,
  output logic [INSTR_W-1:0] imemAddr,
  input  logic               imemReady,
  input  logic [INSTR_W-1:0] imemData,
  output logic [INSTR_W-1:0] instructionOUT,
  output logic [INSTR_W-1:0] pcOUT,
  output logic [INSTR_W-1:0] pcPlus4OUT,
  output logic               fdWe
);

  fetch_state_t       state, next_state;
  logic [INSTR_W-1:0] req_addr, load_val, target;
  logic [INSTR_W-1:0] pending_pc, pending_next;
  logic [INSTR_W-1:0] buf_instr, buf_pc;
  logic               load, buf_we, delivered;

  assign target   = redirectTarget & ~32'h3;
  assign imemAddr = req_addr & ~32'h3;

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .d     (load_val),
    .q     (req_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pending_pc <= '0;
      buf_instr  <= NOP_INSTR;
      buf_pc     <= '0;
    end else begin
      state      <= next_state;
      pending_pc <= pending_next;
      if (buf_we) begin
        buf_instr <= imemData;
        buf_pc    <= req_addr;
      end
    end
  end

  always_comb begin
    next_state     = state;
    pending_next   = pending_pc;
    load           = 1'b0;
    load_val       = req_addr;
    buf_we         = 1'b0;
    delivered      = 1'b0;
    instructionOUT = NOP_INSTR;
    pcOUT          = '0;
    fdWe           = 1'b0;
    imemReq        = !reset && (state != HOLD);

    if (reset) begin
      next_state = FETCH;
    end else if (redirect) begin
      // Flush IF/ID even under stall; the in-flight word is never used.
      fdWe = 1'b1;
      case (state)
        FETCH: begin
          if (imemReady) begin
            load     = 1'b1;
            load_val = target;
          end else begin
            next_state   = DISCARD;
            pending_next = target;
          end
        end
        DISCARD: begin
          pending_next = target;
          if (imemReady) begin
            load       = 1'b1;
            load_val   = target;
            next_state = FETCH;
          end
        end
        default: begin
          load       = 1'b1;
          load_val   = target;
          next_state = FETCH;
        end
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imemReady) begin
            if (stall) begin
              buf_we     = 1'b1;
              next_state = HOLD;
            end else begin
              delivered      = 1'b1;
              fdWe           = 1'b1;
              instructionOUT = imemData;
              pcOUT          = req_addr;
              load           = 1'b1;
              load_val       = req_addr + 32'd4;
            end
          end else begin
            fdWe = ~stall;
          end
        end
        HOLD: begin
          if (!stall) begin
            delivered      = 1'b1;
            fdWe           = 1'b1;
            instructionOUT = buf_instr;
            pcOUT          = buf_pc;
            load           = 1'b1;
            load_val       = buf_pc + 32'd4;
            next_state     = FETCH;
          end
        end
        DISCARD: begin
          fdWe = ~stall;
          if (imemReady) begin
            load       = 1'b1;
            load_val   = pending_pc;
            next_state = FETCH;
          end
        end
        default: next_state = FETCH;
      endcase
    end

    pcPlus4OUT = delivered ? pcOUT + 32'd4 : '0;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - vector-table and scoreboard bench for fetch_stage
import fetch_stage_pkg::*;

module tb_fetch_stage;

  typedef struct {
    logic        rst, st, rd;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] instr, pc, pc4;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imemReady;
  logic [31:0] redirectTarget, imemData;
  logic        imemReq, fdWe;
  logic [31:0] imemAddr, instructionOUT, pcOUT, pcPlus4OUT;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_idx = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirectTarget (redirectTarget),
    .imemReq        (imemReq),
    .imemAddr       (imemAddr),
    .imemReady      (imemReady),
    .imemData       (imemData),
    .instructionOUT (instructionOUT),
    .pcOUT          (pcOUT),
    .pcPlus4OUT     (pcPlus4OUT),
    .fdWe           (fdWe)
  );

  function automatic logic [31:0] w(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  task automatic add(input logic rst, st, rd, input logic [31:0] tgt,
                     input logic rdy, input logic [31:0] data,
                     input logic req, input logic [31:0] addr, input logic we,
                     input logic [31:0] instr, pc, pc4);
    vec_t v;
    v.rst = rst; v.st = st; v.rd = rd; v.tgt = tgt; v.rdy = rdy; v.data = data;
    v.req = req; v.addr = addr; v.we = we; v.instr = instr; v.pc = pc; v.pc4 = pc4;
    vecs.push_back(v);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      checks++;
      if (imemReq !== e.req || imemAddr !== e.addr || fdWe !== e.we ||
          instructionOUT !== e.instr || pcOUT !== e.pc || pcPlus4OUT !== e.pc4) begin
        errors++;
        $display("FAIL vec%0d: got req=%b addr=%h we=%b instr=%h pc=%h pc4=%h, expected req=%b addr=%h we=%b instr=%h pc=%h pc4=%h",
                 vec_idx, imemReq, imemAddr, fdWe, instructionOUT, pcOUT, pcPlus4OUT,
                 e.req, e.addr, e.we, e.instr, e.pc, e.pc4);
      end
      vec_idx++;
    end
  end

  initial begin
    // Zero-wait streaming from reset, including reset-over-ready
    add(1,0,0,0,            1,w(0),          0,32'h0,1'b0,NOP_INSTR,0,0);
    add(0,0,0,0,            1,w(0),          1,32'h0,1'b1,w(0),32'h0,32'h4);
    add(0,0,0,0,            1,w(4),          1,32'h4,1'b1,w(4),32'h4,32'h8);
    // Stall on returned word at PC 8 for three cycles
    add(0,1,0,0,            1,32'h00500093,  1,32'h8,1'b0,NOP_INSTR,0,0);
    add(0,1,0,0,            0,0,             0,32'h8,1'b0,NOP_INSTR,0,0);
    add(0,1,0,0,            0,0,             0,32'h8,1'b0,NOP_INSTR,0,0);
    add(0,0,0,0,            0,0,             0,32'h8,1'b1,32'h00500093,32'h8,32'hC);
    add(0,0,0,0,            1,w(12),         1,32'hC,1'b1,w(12),32'hC,32'h10);
    // Waiting memory: bubble gated by stall
    add(0,1,0,0,            0,0,             1,32'h10,1'b0,NOP_INSTR,0,0);
    add(0,0,0,0,            0,0,             1,32'h10,1'b1,NOP_INSTR,0,0);
    // Redirect while request outstanding at 16
    add(0,0,1,32'h103,      0,0,             1,32'h10,1'b1,NOP_INSTR,0,0);
    add(0,0,0,0,            1,w(16),         1,32'h10,1'b1,NOP_INSTR,0,0);
    add(0,0,0,0,            1,w(32'h100),    1,32'h100,1'b1,w(32'h100),32'h100,32'h104);
    // Redirect with ready and stall in FETCH
    add(0,1,1,32'h200,      1,w(32'h104),    1,32'h104,1'b1,NOP_INSTR,0,0);
    add(0,0,0,0,            1,w(32'h200),    1,32'h200,1'b1,w(32'h200),32'h200,32'h204);
    // Redirect plus stall in HOLD
    add(0,1,0,0,            1,w(32'h204),    1,32'h204,1'b0,NOP_INSTR,0,0);
    add(0,1,1,32'h302,      0,0,             0,32'h204,1'b1,NOP_INSTR,0,0);
    add(0,0,0,0,            1,w(32'h300),    1,32'h300,1'b1,w(32'h300),32'h300,32'h304);
    // Second redirect in DISCARD overwrites the pending target
    add(0,0,1,32'h400,      0,0,             1,32'h304,1'b1,NOP_INSTR,0,0);
    add(0,0,1,32'h501,      0,0,             1,32'h304,1'b1,NOP_INSTR,0,0);
    add(0,0,0,0,            1,w(32'h304),    1,32'h304,1'b1,NOP_INSTR,0,0);
    add(0,0,0,0,            1,w(32'h500),    1,32'h500,1'b1,w(32'h500),32'h500,32'h504);
    // Address wrap at the top of memory
    add(0,0,1,32'hFFFFFFFF, 1,w(32'h504),    1,32'h504,1'b1,NOP_INSTR,0,0);
    add(0,0,0,0,            1,w(32'hFFFFFFFC),1,32'hFFFFFFFC,1'b1,w(32'hFFFFFFFC),32'hFFFFFFFC,32'h0);
    add(0,0,0,0,            1,w(0),          1,32'h0,1'b1,w(0),32'h0,32'h4);
    // Reset pulsed while discarding
    add(0,0,1,32'h80,       0,0,             1,32'h4,1'b1,NOP_INSTR,0,0);
    add(1,0,0,0,            1,w(4),          0,32'h4,1'b0,NOP_INSTR,0,0);
    add(0,0,0,0,            0,0,             1,32'h0,1'b1,NOP_INSTR,0,0);
    add(0,0,0,0,            1,w(0),          1,32'h0,1'b1,w(0),32'h0,32'h4);

    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirectTarget = '0;
    imemReady = 1'b0; imemData = '0;
    @(posedge clk);
    foreach (vecs[i]) begin
      #1;
      reset = vecs[i].rst; stall = vecs[i].st; redirect = vecs[i].rd;
      redirectTarget = vecs[i].tgt; imemReady = vecs[i].rdy; imemData = vecs[i].data;
      sb.push_back(vecs[i]);
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
